exec_control_unit: RTL and testbench

//  Multi-cycle control unit that drives the ALU and consumes its flags. Fetches from

---
 rtl/exec_control_unit.sv | 254 +++++++++++++++++++++++++
 tb/tb_exec_control_unit.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_control_unit.sv
// Multi-cycle fetch/decode/execute sequencer for the RISC core: drives ALU controls, imem/dmem handshakes and RF writes.
// Optional macro ILLEGAL_TRAP_EN: undefined opcodes lock the unit in a trap state and raise illegal_op.
module exec_control_unit #(
   parameter int              PC_W     = 16,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst_n,
`ifdef ILLEGAL_TRAP_EN
   output logic            illegal_op,
`endif
   output logic [PC_W-1:0] imem_addr,
   output logic            imem_req,
   input  logic            imem_ack,
   input  logic [31:0]     imem_rdata,
   output logic [3:0]      rf_ra,
   output logic [3:0]      rf_rb,
   output logic [3:0]      rf_wa,
   output logic [31:0]     imm_ext,
   output logic            alu_src_imm,
   output logic [5:0]      alu_opcode,
   input  logic            alu_zero,
   input  logic            alu_bgt,
   input  logic            alu_blt,
   output logic            dmem_req,
   output logic            dmem_we,
   input  logic            dmem_ack,
   output logic            rf_we,
   output logic            rf_wsel,
   output logic            rf_we_post,
   output logic            retired
);

   localparam logic [5:0] OP_ANDI  = 6'd3;
   localparam logic [5:0] OP_ADDI  = 6'd4;
   localparam logic [5:0] OP_LW    = 6'd5;
   localparam logic [5:0] OP_LWPOI = 6'd6;
   localparam logic [5:0] OP_SW    = 6'd7;
   localparam logic [5:0] OP_BGT   = 6'd8;
   localparam logic [5:0] OP_BLT   = 6'd9;
   localparam logic [5:0] OP_BEQ   = 6'd10;
   localparam logic [5:0] OP_BNE   = 6'd11;
   localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd5
   } state_t;

   state_t          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [31:0]     ir_q, ir_d;
   logic            imem_req_q, imem_req_d;
   logic            dmem_req_q, dmem_req_d;
   logic            dmem_we_q, dmem_we_d;
   logic            rf_we_q, rf_we_d;
   logic            rf_wsel_q, rf_wsel_d;
   logic            rf_we_post_q, rf_we_post_d;
   logic            retired_q, retired_d;
   logic [5:0]      alu_opcode_q, alu_opcode_d;
`ifdef ILLEGAL_TRAP_EN
   logic            illegal_q, illegal_d;
`endif

   logic [5:0]      op;
   logic [13:0]     imm;
   logic [31:0]     imm_sext;
   logic            op_legal;
   logic            op_alu;
   logic            br_taken;
   logic [PC_W-1:0] pc_inc;
   logic [PC_W-1:0] pc_br;

   // Instruction field decode; held stable from DECODE until the instruction retires
   always_comb begin
      op       = ir_q[31:26];
      imm      = ir_q[13:0];
      imm_sext = {{18{imm[13]}}, imm};
      op_legal = (op <= OP_BNE);
      op_alu   = (op <= OP_ADDI);
      rf_ra    = ir_q[21:18];
      rf_wa    = ir_q[25:22];
      if (op == OP_SW) begin
         rf_rb = ir_q[25:22];
      end else begin
         rf_rb = ir_q[17:14];
      end
      if (op == OP_ANDI) begin
         imm_ext = {18'd0, imm};
      end else begin
         imm_ext = imm_sext;
      end
      if ((op >= OP_ANDI) && (op <= OP_SW)) begin
         alu_src_imm = 1'b1;
      end else begin
         alu_src_imm = 1'b0;
      end
      case (op)
         OP_BGT:  br_taken = alu_bgt;
         OP_BLT:  br_taken = alu_blt;
         OP_BEQ:  br_taken = alu_zero;
         OP_BNE:  br_taken = ~alu_zero;
         default: br_taken = 1'b0;
      endcase
      pc_inc = pc_q + PC_ONE;
      pc_br  = pc_inc + imm_sext[PC_W-1:0];
   end

   // Next-state and next-output logic; pulse outputs default low, request flags track the target state
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      ir_d         = ir_q;
      imem_req_d   = 1'b0;
      dmem_req_d   = 1'b0;
      dmem_we_d    = 1'b0;
      rf_we_d      = 1'b0;
      rf_wsel_d    = 1'b0;
      rf_we_post_d = 1'b0;
      retired_d    = 1'b0;
      alu_opcode_d = alu_opcode_q;
`ifdef ILLEGAL_TRAP_EN
      illegal_d    = illegal_q;
`endif
      case (state_q)
         S_FETCH: begin
            // the first cycle after reset has imem_req low, so a stray ack there is ignored
            if (imem_req_q && imem_ack) begin
               ir_d    = imem_rdata;
               state_d = S_DECODE;
            end else begin
               imem_req_d = 1'b1;
            end
         end
         S_DECODE: begin
            if (op_legal) begin
               alu_opcode_d = op;
               state_d      = S_EXEC;
            end else begin
`ifdef ILLEGAL_TRAP_EN
               illegal_d = 1'b1;
               state_d   = S_TRAP;
`else
               pc_d       = pc_inc;
               retired_d  = 1'b1;
               imem_req_d = 1'b1;
               state_d    = S_FETCH;
`endif
            end
         end
         S_EXEC: begin
            if (op_alu) begin
               rf_we_d = 1'b1;
               state_d = S_WB;
            end else if (op <= OP_SW) begin
               dmem_req_d = 1'b1;
               dmem_we_d  = (op == OP_SW);
               state_d    = S_MEM;
            end else begin
               pc_d       = br_taken ? pc_br : pc_inc;
               retired_d  = 1'b1;
               imem_req_d = 1'b1;
               state_d    = S_FETCH;
            end
         end
         S_MEM: begin
            if (dmem_req_q && dmem_ack) begin
               if (op == OP_SW) begin
                  pc_d       = pc_inc;
                  retired_d  = 1'b1;
                  imem_req_d = 1'b1;
                  state_d    = S_FETCH;
               end else begin
                  rf_we_d      = 1'b1;
                  rf_wsel_d    = 1'b1;
                  rf_we_post_d = (op == OP_LWPOI);
                  state_d      = S_WB;
               end
            end else begin
               dmem_req_d = 1'b1;
               dmem_we_d  = dmem_we_q;
            end
         end
         S_WB: begin
            pc_d       = pc_inc;
            retired_d  = 1'b1;
            imem_req_d = 1'b1;
            state_d    = S_FETCH;
         end
`ifdef ILLEGAL_TRAP_EN
         S_TRAP: begin
            state_d = S_TRAP;
         end
`endif
         default: begin
            imem_req_d = 1'b1;
            state_d    = S_FETCH;
         end
      endcase
   end

   // State and registered-output flops with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_FETCH;
         pc_q         <= RESET_PC;
         ir_q         <= 32'd0;
         imem_req_q   <= 1'b0;
         dmem_req_q   <= 1'b0;
         dmem_we_q    <= 1'b0;
         rf_we_q      <= 1'b0;
         rf_wsel_q    <= 1'b0;
         rf_we_post_q <= 1'b0;
         retired_q    <= 1'b0;
         alu_opcode_q <= 6'd0;
`ifdef ILLEGAL_TRAP_EN
         illegal_q    <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         ir_q         <= ir_d;
         imem_req_q   <= imem_req_d;
         dmem_req_q   <= dmem_req_d;
         dmem_we_q    <= dmem_we_d;
         rf_we_q      <= rf_we_d;
         rf_wsel_q    <= rf_wsel_d;
         rf_we_post_q <= rf_we_post_d;
         retired_q    <= retired_d;
         alu_opcode_q <= alu_opcode_d;
`ifdef ILLEGAL_TRAP_EN
         illegal_q    <= illegal_d;
`endif
      end
   end

   assign imem_addr  = pc_q;
   assign imem_req   = imem_req_q;
   assign dmem_req   = dmem_req_q;
   assign dmem_we    = dmem_we_q;
   assign rf_we      = rf_we_q;
   assign rf_wsel    = rf_wsel_q;
   assign rf_we_post = rf_we_post_q;
   assign retired    = retired_q;
   assign alu_opcode = alu_opcode_q;
`ifdef ILLEGAL_TRAP_EN
   assign illegal_op = illegal_q;
`endif

endmodule

// File: tb/tb_exec_control_unit.sv
// Self-checking bench for exec_control_unit: acts as imem/dmem/ALU-flag source and compares against an instruction-level model.
module tb_exec_control_unit;

   logic        clk = 1'b0;
   logic        rst_n;
`ifdef ILLEGAL_TRAP_EN
   logic        illegal_op;
`endif
   logic [15:0] imem_addr;
   logic        imem_req;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [3:0]  rf_ra, rf_rb, rf_wa;
   logic [31:0] imm_ext;
   logic        alu_src_imm;
   logic [5:0]  alu_opcode;
   logic        alu_zero, alu_bgt, alu_blt;
   logic        dmem_req, dmem_we, dmem_ack;
   logic        rf_we, rf_wsel, rf_we_post, retired;

   int checks   = 0;
   int failures = 0;
   int model_pc = 0;
   bit skip_wait = 1'b0;

   always #5 clk = ~clk;

   exec_control_unit #(.PC_W(16), .RESET_PC(16'd0)) dut (
      .clk(clk), .rst_n(rst_n),
`ifdef ILLEGAL_TRAP_EN
      .illegal_op(illegal_op),
`endif
      .imem_addr(imem_addr), .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .rf_ra(rf_ra), .rf_rb(rf_rb), .rf_wa(rf_wa), .imm_ext(imm_ext), .alu_src_imm(alu_src_imm),
      .alu_opcode(alu_opcode), .alu_zero(alu_zero), .alu_bgt(alu_bgt), .alu_blt(alu_blt),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
      .rf_we(rf_we), .rf_wsel(rf_wsel), .rf_we_post(rf_we_post), .retired(retired)
   );

   function automatic logic [31:0] mk(input int op, input int rd, input int rs, input int rt, input int imm);
      logic [31:0] w;
      w = {op[5:0], rd[3:0], rs[3:0], rt[3:0], imm[13:0]};
      return w;
   endfunction

   // Executes one instruction end to end and checks it against the instruction-level model
   task automatic run_instr(input logic [31:0] instr, input int wi, input int wd,
                            input bit z, input bit gt, input bit lt);
      int op, rd, rs, rt, immv, off, exp_lat, exp_pc, exp_rb, exp_dcnt, exp_wecnt, exp_post;
      bit is_alu, is_ld, is_st, is_br, taken, exp_src, exp_wsel;
      logic [31:0] exp_imm;
      int cyc, iw, dw, since_ack, dcnt, wecnt, postcnt, stray, bad_we, bad_wsel, bad_wa;
      bit started, done;
      op = int'(instr[31:26]); rd = int'(instr[25:22]); rs = int'(instr[21:18]);
      rt = int'(instr[17:14]); immv = int'(instr[13:0]);
      off = (immv >= 8192) ? immv - 16384 : immv;
      is_alu = (op <= 4); is_ld = (op == 5 || op == 6); is_st = (op == 7);
      is_br = (op >= 8 && op <= 11);
      taken = (op == 8 && gt) || (op == 9 && lt) || (op == 10 && z) || (op == 11 && !z);
      exp_lat = is_alu ? 4 : is_ld ? 5 + wd : is_st ? 4 + wd : is_br ? 3 : 2;
      exp_lat += wi;
      exp_pc = (is_br && taken) ? ((model_pc + 1 + off) & 'hFFFF) : ((model_pc + 1) & 'hFFFF);
      exp_rb = is_st ? rd : rt;
      exp_src = (op >= 3 && op <= 7);
      exp_imm = (op == 3) ? 32'(immv) : 32'(off);
      exp_dcnt = (is_ld || is_st) ? wd + 1 : 0;
      exp_wecnt = (is_alu || is_ld) ? 1 : 0;
      exp_wsel = is_ld;
      exp_post = (op == 6) ? 1 : 0;
      alu_zero = z; alu_bgt = gt; alu_blt = lt;
      cyc = 0; iw = 0; dw = 0; since_ack = -1; dcnt = 0; wecnt = 0; postcnt = 0; stray = 0;
      bad_we = 0; bad_wsel = 0; bad_wa = 0; started = 1'b0; done = 1'b0;
      for (int k = 0; k < 200 && !done; k++) begin
         if (!skip_wait) @(negedge clk);
         skip_wait = 1'b0;
         if (retired === 1'b1 && started) begin
            done = 1'b1;
            skip_wait = 1'b1;
         end else begin
            if (imem_req === 1'b1) started = 1'b1;
            if (started) cyc++;
            if (since_ack >= 0) since_ack++;
            if (since_ack == 2 && op <= 11) begin
               checks++;
               if (alu_opcode !== op[5:0]) begin
                  failures++;
                  $display("FAIL alu_opcode: got %0d expected %0d", alu_opcode, op);
               end
               checks++;
               if (rf_ra !== rs[3:0] || rf_rb !== exp_rb[3:0] || imm_ext !== exp_imm || alu_src_imm !== exp_src) begin
                  failures++;
                  $display("FAIL decode op=%0d: ra/rb/imm/src got %0d/%0d/%h/%0d expected %0d/%0d/%h/%0d",
                           op, rf_ra, rf_rb, imm_ext, alu_src_imm, rs, exp_rb, exp_imm, exp_src);
               end
            end
            imem_ack = 1'b0;
            dmem_ack = 1'b0;
            if (imem_req === 1'b1 && since_ack < 0) begin
               if (iw == wi) begin
                  checks++;
                  if (imem_addr !== model_pc[15:0]) begin
                     failures++;
                     $display("FAIL imem_addr: got %h expected %h", imem_addr, model_pc[15:0]);
                  end
                  imem_ack = 1'b1;
                  imem_rdata = instr;
                  since_ack = 0;
               end else begin
                  iw++;
               end
            end
            if (dmem_req === 1'b1) begin
               dcnt++;
               if (dmem_we !== is_st) bad_we++;
               if (dw == wd) dmem_ack = 1'b1;
               else dw++;
            end
            if (rf_we === 1'b1) begin
               wecnt++;
               if (rf_wsel !== exp_wsel) bad_wsel++;
               if (rf_wa !== rd[3:0]) bad_wa++;
               if (rf_we_post === 1'b1) postcnt++;
            end else if (rf_we_post === 1'b1) begin
               stray++;
            end
         end
      end
      imem_ack = 1'b0;
      dmem_ack = 1'b0;
      checks++;
      if (!done) begin
         failures++;
         $display("FAIL retire_timeout op=%0d: got no retire expected retire", op);
      end else begin
         checks++;
         if (cyc != exp_lat) begin
            failures++;
            $display("FAIL latency op=%0d: got %0d expected %0d", op, cyc, exp_lat);
         end
         checks++;
         if (imem_addr !== exp_pc[15:0]) begin
            failures++;
            $display("FAIL next_pc op=%0d: got %h expected %h", op, imem_addr, exp_pc[15:0]);
         end
         checks++;
         if (dcnt != exp_dcnt || bad_we != 0) begin
            failures++;
            $display("FAIL dmem op=%0d: req_cycles %0d bad_we %0d expected %0d and 0", op, dcnt, bad_we, exp_dcnt);
         end
         checks++;
         if (wecnt != exp_wecnt || bad_wsel != 0 || bad_wa != 0) begin
            failures++;
            $display("FAIL rf_we op=%0d: pulses %0d bad_wsel %0d bad_wa %0d expected %0d,0,0",
                     op, wecnt, bad_wsel, bad_wa, exp_wecnt);
         end
         checks++;
         if (postcnt != exp_post || stray != 0) begin
            failures++;
            $display("FAIL rf_we_post op=%0d: paired %0d stray %0d expected %0d,0", op, postcnt, stray, exp_post);
         end
      end
      model_pc = exp_pc;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; imem_rdata = 32'd0;
      alu_zero = 1'b0; alu_bgt = 1'b0; alu_blt = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (imem_req !== 1'b0 || dmem_req !== 1'b0 || dmem_we !== 1'b0 || rf_we !== 1'b0 ||
          rf_we_post !== 1'b0 || retired !== 1'b0) begin
         failures++;
         $display("FAIL reset_ctrl: req/dreq/we/rfwe/post/ret got %b%b%b%b%b%b expected 000000",
                  imem_req, dmem_req, dmem_we, rf_we, rf_we_post, retired);
      end
      checks++;
      if (imem_addr !== 16'd0 || alu_opcode !== 6'd0 || alu_src_imm !== 1'b0) begin
         failures++;
         $display("FAIL reset_vals: pc %h opc %0d src %b expected 0000 0 0", imem_addr, alu_opcode, alu_src_imm);
      end
      rst_n = 1'b1;
      imem_ack = 1'b1;
      imem_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 16'd0) begin
         failures++;
         $display("FAIL ack_without_req: req %b pc %h expected 1 0000", imem_req, imem_addr);
      end
      imem_ack = 1'b0;
      model_pc = 0;
      skip_wait = 1'b1;
   endtask

   task automatic test_add();
      run_instr(mk(1, 3, 1, 2, 0), 0, 0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_branch();
      for (int i = 0; i < 4; i++) run_instr(mk(4, i, i + 1, 0, 7), 0, 0, 1'b0, 1'b0, 1'b0);
      run_instr(mk(10, 0, 1, 2, -2), 0, 0, 1'b1, 1'b0, 1'b0);
      run_instr(mk(3, 5, 6, 0, 14'h3FFF), 1, 0, 1'b0, 1'b0, 1'b0);
      run_instr(mk(10, 0, 1, 2, -2), 0, 0, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic test_wrap();
      run_instr(mk(11, 0, 3, 4, -8), 0, 0, 1'b0, 1'b0, 1'b1);
      run_instr(mk(11, 0, 3, 4, 1), 0, 0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_lwpoi();
      run_instr(mk(6, 9, 2, 0, 4), 0, 3, 1'b0, 1'b0, 1'b0);
      run_instr(mk(5, 8, 2, 0, -3), 2, 0, 1'b0, 1'b0, 1'b0);
      run_instr(mk(7, 8, 2, 0, 5), 0, 1, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_random();
      logic [31:0] r;
      int op;
      for (int i = 0; i < 40; i++) begin
         r = $urandom();
`ifdef ILLEGAL_TRAP_EN
         op = $urandom_range(0, 11);
`else
         op = $urandom_range(0, 15);
`endif
         run_instr({op[5:0], r[25:0]}, $urandom_range(0, 2), $urandom_range(0, 3),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
   endtask

   task automatic test_reset_mid_mem();
      bit fetched, seen;
      fetched = 1'b0; seen = 1'b0;
      for (int k = 0; k < 40 && !seen; k++) begin
         if (!skip_wait) @(negedge clk);
         skip_wait = 1'b0;
         imem_ack = 1'b0;
         dmem_ack = 1'b0;
         if (imem_req === 1'b1 && !fetched) begin
            imem_ack = 1'b1;
            imem_rdata = mk(7, 1, 2, 3, 9);
            fetched = 1'b1;
         end
         if (dmem_req === 1'b1) seen = 1'b1;
      end
      imem_ack = 1'b0;
      checks++;
      if (!seen) begin
         failures++;
         $display("FAIL mid_mem_setup: got no dmem_req expected dmem_req");
      end
      rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if (dmem_req !== 1'b0 || imem_req !== 1'b0 || dmem_we !== 1'b0 || imem_addr !== 16'd0) begin
         failures++;
         $display("FAIL reset_mid_mem: dreq %b ireq %b we %b pc %h expected 0 0 0 0000",
                  dmem_req, imem_req, dmem_we, imem_addr);
      end
      rst_n = 1'b1;
      model_pc = 0;
      skip_wait = 1'b0;
      run_instr(mk(2, 4, 5, 6, 0), 0, 0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_illegal();
`ifdef ILLEGAL_TRAP_EN
      bit fetched;
      int bad;
      fetched = 1'b0; bad = 0;
      for (int k = 0; k < 12; k++) begin
         if (!skip_wait) @(negedge clk);
         skip_wait = 1'b0;
         imem_ack = 1'b0;
         if (imem_req === 1'b1 && !fetched) begin
            imem_ack = 1'b1;
            imem_rdata = mk(63, 1, 2, 3, 0);
            fetched = 1'b1;
         end else if (k >= 4) begin
            if (illegal_op !== 1'b1 || retired !== 1'b0 || imem_req !== 1'b0 || imem_addr !== model_pc[15:0]) bad++;
         end
      end
      imem_ack = 1'b0;
      checks++;
      if (bad != 0 || !fetched) begin
         failures++;
         $display("FAIL trap: bad cycles %0d fetched %b expected 0 1", bad, fetched);
      end
      rst_n = 1'b0;
      @(negedge clk);
      checks++;
      if (illegal_op !== 1'b0) begin
         failures++;
         $display("FAIL trap_reset: illegal_op %b expected 0", illegal_op);
      end
      rst_n = 1'b1;
      model_pc = 0;
`else
      run_instr(mk(63, 1, 2, 3, 0), 0, 0, 1'b0, 1'b0, 1'b0);
      run_instr(mk(12, 1, 2, 3, 0), 1, 0, 1'b0, 1'b0, 1'b0);
`endif
   endtask

   initial begin
      test_reset();
      test_add();
      test_branch();
      test_wrap();
      test_lwpoi();
      test_random();
      test_reset_mid_mem();
      test_illegal();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
